// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
// Shared types and constants for the Pac-Man sprite renderer:
//   dir_t        - facing direction as latched from the Dir input
//   anim_state_t - animation life cycle (ALIVE -> DYING -> DEAD -> ALIVE)
//   PALETTE      - 16-entry RGB888 palette, entry 0 is transparent
//   CHOMP_SEQ    - ROM frame order for the chomp cycle (wide, half, closed, half)
//   orient_xy    - maps sprite-local (lx,ly) to ROM (sx,sy) for a direction
// -----------------------------------------------------------------------------
package pacman_pkg;

    localparam int SPR_SIZE     = 16;
    localparam int ANIM_DIV     = 4;
    localparam int DEATH_FRAMES = 8;

    // First ROM frame of the death animation; frames 4..11.
    localparam logic [3:0] DEATH_BASE = 4'd4;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        DYING = 2'd1,
        DEAD  = 2'd2
    } anim_state_t;

    localparam logic [23:0] PALETTE [0:15] = '{
        24'h000000, 24'hFFFF00, 24'h000000, 24'hFFFFFF,
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFB8FF,
        24'h00FFFF, 24'hFFB852, 24'h2121DE, 24'hDEDEFF,
        24'hFF8000, 24'h808080, 24'h400040, 24'hC0C0C0
    };

    localparam logic [3:0] CHOMP_SEQ [0:3] = '{4'd0, 4'd1, 4'd2, 4'd1};

    // Returns {sy, sx}. The ROM art faces right; other facings are
    // produced by mirroring (LEFT) or transposing (UP/DOWN).
    function automatic logic [7:0] orient_xy(input dir_t dir,
                                             input logic [3:0] lx,
                                             input logic [3:0] ly);
        logic [7:0] sxy;
        case (dir)
            RIGHT:   sxy = {ly, lx};
            LEFT:    sxy = {ly, 4'd15 - lx};
            UP:      sxy = {lx, 4'd15 - ly};
            DOWN:    sxy = {lx, ly};
            default: sxy = {ly, lx};
        endcase
        return sxy;
    endfunction

endpackage

// File: rtl/pacman_anim_fsm.sv
// -----------------------------------------------------------------------------
// pacman_anim_fsm
// Chomp / death animation sequencer, advanced by frame_tick.
// Ports:
//   clk, rst_n      - pixel clock, asynchronous active-low reset
//   i_frame_tick    - one pulse per video frame
//   i_moving        - chomp cycle only advances while high
//   i_die           - start death sequence (ALIVE only)
//   i_respawn       - leave DEAD (ignored if i_die is also high)
//   o_frame         - ROM frame number for the current state
//   o_visible       - low while DEAD
//   o_state         - current animation state
//   o_death_done    - one-cycle pulse on DYING -> DEAD
// -----------------------------------------------------------------------------
module pacman_anim_fsm
    import pacman_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frame_tick,
    input  logic        i_moving,
    input  logic        i_die,
    input  logic        i_respawn,
    output logic [3:0]  o_frame,
    output logic        o_visible,
    output anim_state_t o_state,
    output logic        o_death_done
);

    localparam int                DIV_W    = $clog2(ANIM_DIV);
    localparam int                IDX_W    = $clog2(DEATH_FRAMES);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(ANIM_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DEATH_FRAMES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    anim_state_t      r_state;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_phase;
    logic [IDX_W-1:0] r_death_idx;
    logic [3:0]       r_frame;
    logic             r_visible;
    logic             r_death_done;

    logic [1:0]       w_phase_next;
    logic [IDX_W-1:0] w_idx_next;

    assign w_phase_next = r_phase + 2'd1;
    assign w_idx_next   = r_death_idx + IDX_ONE;

    // Animation state machine; frame/visible are kept registered alongside
    // the state so they change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ALIVE;
            r_div        <= '0;
            r_phase      <= 2'd0;
            r_death_idx  <= '0;
            r_frame      <= 4'd0;
            r_visible    <= 1'b1;
            r_death_done <= 1'b0;
        end else begin
            r_death_done <= 1'b0;
            case (r_state)
                ALIVE: begin
                    // die has priority: a coincident frame_tick is dropped.
                    if (i_die) begin
                        r_state     <= DYING;
                        r_div       <= '0;
                        r_death_idx <= '0;
                        r_frame     <= DEATH_BASE;
                    end else if (i_frame_tick && i_moving) begin
                        if (r_div == DIV_LAST) begin
                            r_div   <= '0;
                            r_phase <= w_phase_next;
                            r_frame <= CHOMP_SEQ[w_phase_next];
                        end else begin
                            r_div <= r_div + DIV_ONE;
                        end
                    end
                end
                DYING: begin
                    if (i_frame_tick) begin
                        if (r_div == DIV_LAST) begin
                            r_div <= '0;
                            // Last death frame is held a full divider period.
                            if (r_death_idx == IDX_LAST) begin
                                r_state      <= DEAD;
                                r_frame      <= 4'd0;
                                r_visible    <= 1'b0;
                                r_death_done <= 1'b1;
                            end else begin
                                r_death_idx <= w_idx_next;
                                r_frame     <= DEATH_BASE + 4'(w_idx_next);
                            end
                        end else begin
                            r_div <= r_div + DIV_ONE;
                        end
                    end
                end
                DEAD: begin
                    if (i_respawn && !i_die) begin
                        r_state   <= ALIVE;
                        r_div     <= '0;
                        r_phase   <= 2'd0;
                        r_frame   <= CHOMP_SEQ[0];
                        r_visible <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ALIVE;
                    r_div     <= '0;
                    r_phase   <= 2'd0;
                    r_frame   <= 4'd0;
                    r_visible <= 1'b1;
                end
            endcase
        end
    end

    assign o_frame      = r_frame;
    assign o_visible    = r_visible;
    assign o_state      = r_state;
    assign o_death_done = r_death_done;

endmodule

// File: rtl/pacman_sprite_renderer.sv
// -----------------------------------------------------------------------------
// pacman_sprite_renderer
// Pixel source for color_mapper: hit-tests the 16x16 Pac-Man sprite against
// the current draw position, fetches the palette index from an external
// synchronous ROM and outputs RGB two pixel clocks later.
// Ports:
//   Clk, Reset              - pixel clock, asynchronous active-low reset
//   frame_tick              - start of vertical blank; latches PacX/PacY/Dir
//   DrawX, DrawY            - current pixel
//   PacX, PacY, Dir         - sprite top-left and facing
//   moving, die, respawn    - animation controls
//   rom_addr / rom_data     - {frame,sy,sx} out, palette index back 1 Clk later
//   is_ball                 - opaque sprite pixel
//   pac_man_cut_data_out_*  - sprite colour (0 when not is_ball)
//   DrawX_d, DrawY_d        - DrawX/DrawY aligned with the colour outputs
//   death_done              - pulse when the death animation finishes
// -----------------------------------------------------------------------------
module pacman_sprite_renderer
    import pacman_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  PacX,
    input  logic [9:0]  PacY,
    input  logic [1:0]  Dir,
    input  logic        moving,
    input  logic        die,
    input  logic        respawn,
    output logic [11:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic        is_ball,
    output logic [7:0]  pac_man_cut_data_out_R,
    output logic [7:0]  pac_man_cut_data_out_G,
    output logic [7:0]  pac_man_cut_data_out_B,
    output logic [9:0]  DrawX_d,
    output logic [9:0]  DrawY_d,
    output logic        death_done
);

    logic [9:0]  r_pos_x;
    logic [9:0]  r_pos_y;
    dir_t        r_dir;

    logic        r_in_box_s1;
    logic [9:0]  r_x_s1;
    logic [9:0]  r_y_s1;

    logic        r_ball_s2;
    logic [23:0] r_rgb_s2;
    logic [9:0]  r_x_s2;
    logic [9:0]  r_y_s2;

    logic [3:0]  w_frame;
    logic        w_visible;
    anim_state_t w_state;
    logic        w_death_done;

    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_in_box;
    logic [3:0]  w_lx;
    logic [3:0]  w_ly;
    dir_t        w_dir_eff;
    logic [7:0]  w_sxy;
    logic        w_opaque;

    pacman_anim_fsm u_anim (
        .clk          (Clk),
        .rst_n        (Reset),
        .i_frame_tick (frame_tick),
        .i_moving     (moving),
        .i_die        (die),
        .i_respawn    (respawn),
        .o_frame      (w_frame),
        .o_visible    (w_visible),
        .o_state      (w_state),
        .o_death_done (w_death_done)
    );

    // Sprite position/facing only change at vertical blank so a frame never tears.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pos_x <= 10'd0;
            r_pos_y <= 10'd0;
            r_dir   <= RIGHT;
        end else if (frame_tick) begin
            r_pos_x <= PacX;
            r_pos_y <= PacY;
            r_dir   <= dir_t'(Dir);
        end
    end

    // 11-bit bounds so a sprite near X/Y=1023 clips instead of wrapping to 0.
    assign w_x_end  = {1'b0, r_pos_x} + 11'(SPR_SIZE);
    assign w_y_end  = {1'b0, r_pos_y} + 11'(SPR_SIZE);
    assign w_in_box = ({1'b0, DrawX} >= {1'b0, r_pos_x}) && ({1'b0, DrawX} < w_x_end) &&
                      ({1'b0, DrawY} >= {1'b0, r_pos_y}) && ({1'b0, DrawY} < w_y_end) &&
                      w_visible;

    // Only the low nibble of DrawX-PacX is needed; it equals the low nibble
    // of the full-width difference.
    assign w_lx      = DrawX[3:0] - r_pos_x[3:0];
    assign w_ly      = DrawY[3:0] - r_pos_y[3:0];
    assign w_dir_eff = (w_state == ALIVE) ? r_dir : RIGHT;
    assign w_sxy     = orient_xy(w_dir_eff, w_lx, w_ly);
    assign rom_addr  = {w_frame, w_sxy};

    assign w_opaque  = r_in_box_s1 && (rom_data != 4'd0);

    // Two-stage pixel pipeline: stage 1 covers the ROM read, stage 2 colours.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_in_box_s1 <= 1'b0;
            r_x_s1      <= 10'd0;
            r_y_s1      <= 10'd0;
            r_ball_s2   <= 1'b0;
            r_rgb_s2    <= 24'd0;
            r_x_s2      <= 10'd0;
            r_y_s2      <= 10'd0;
        end else begin
            r_in_box_s1 <= w_in_box;
            r_x_s1      <= DrawX;
            r_y_s1      <= DrawY;
            r_ball_s2   <= w_opaque;
            r_rgb_s2    <= w_opaque ? PALETTE[rom_data] : 24'd0;
            r_x_s2      <= r_x_s1;
            r_y_s2      <= r_y_s1;
        end
    end

    assign is_ball                = r_ball_s2;
    assign pac_man_cut_data_out_R = r_rgb_s2[23:16];
    assign pac_man_cut_data_out_G = r_rgb_s2[15:8];
    assign pac_man_cut_data_out_B = r_rgb_s2[7:0];
    assign DrawX_d                = r_x_s2;
    assign DrawY_d                = r_y_s2;
    assign death_done             = w_death_done;

endmodule

// File: tb/tb_pacman_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_pacman_sprite_renderer
// Scoreboard bench: each driven pixel pushes its expected output (from a
// counting reference model of the animation) into a queue; a monitor pops and
// compares when the pixel emerges two clocks later. A behavioural sync ROM
// with random contents feeds rom_data.
// -----------------------------------------------------------------------------
module tb_pacman_sprite_renderer;

    logic        Clk;
    logic        Reset;
    logic        frame_tick, moving, die, respawn;
    logic [9:0]  DrawX, DrawY, PacX, PacY;
    logic [1:0]  Dir;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic        is_ball;
    logic [7:0]  out_r, out_g, out_b;
    logic [9:0]  DrawX_d, DrawY_d;
    logic        death_done;

    pacman_sprite_renderer dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .DrawX(DrawX), .DrawY(DrawY), .PacX(PacX), .PacY(PacY), .Dir(Dir),
        .moving(moving), .die(die), .respawn(respawn),
        .rom_addr(rom_addr), .rom_data(rom_data), .is_ball(is_ball),
        .pac_man_cut_data_out_R(out_r), .pac_man_cut_data_out_G(out_g),
        .pac_man_cut_data_out_B(out_b),
        .DrawX_d(DrawX_d), .DrawY_d(DrawY_d), .death_done(death_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [3:0]  rom_mem [0:4095];
    logic [23:0] pal [0:15];
    int          seq [0:3];

    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // State 0=alive, 1=dying, 2=dead. Animation expressed as tick counts.
    int m_state, m_anim_ticks, m_die_ticks, m_px, m_py, m_dir;
    logic [9:0] n_px, n_py;
    logic [1:0] n_dir;
    logic       n_mv;

    task automatic model_reset();
        m_state = 0; m_anim_ticks = 0; m_die_ticks = 0;
        m_px = 0; m_py = 0; m_dir = 0;
    endtask

    task automatic model_pixel(input int x, input int y, output logic ball,
                               output logic [23:0] rgb, output int addr);
        int dx, dy, lx, ly, sx, sy, d, frame, idx;
        logic inb;
        dx = x - m_px;
        dy = y - m_py;
        inb = (dx >= 0) && (dx < 16) && (dy >= 0) && (dy < 16) && (m_state != 2);
        lx = dx & 15;
        ly = dy & 15;
        d = (m_state == 0) ? m_dir : 0;
        case (d)
            1:       begin sx = 15 - lx; sy = ly;      end
            2:       begin sx = 15 - ly; sy = lx;      end
            3:       begin sx = ly;      sy = lx;      end
            default: begin sx = lx;      sy = ly;      end
        endcase
        frame = (m_state == 0) ? seq[(m_anim_ticks / 4) % 4] : 4 + m_die_ticks / 4;
        addr = frame * 256 + sy * 16 + sx;
        idx = int'(rom_mem[addr]);
        ball = inb && (idx != 0);
        rgb = ball ? pal[idx] : 24'd0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { int due; logic ball; logic [23:0] rgb; logic [9:0] x; logic [9:0] y; } pix_t;
    typedef struct { int due; logic done; } done_t;
    pix_t  pix_q[$];
    done_t done_q[$];
    pix_t  mon_p;
    done_t mon_d;

    always @(negedge Clk) begin
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            mon_p = pix_q.pop_front();
            check("is_ball", 32'(is_ball), 32'(mon_p.ball));
            check("rgb", {8'd0, out_r, out_g, out_b}, {8'd0, mon_p.rgb});
            check("drawx_d", 32'(DrawX_d), 32'(mon_p.x));
            check("drawy_d", 32'(DrawY_d), 32'(mon_p.y));
        end
        while (done_q.size() > 0 && done_q[0].due <= cyc) begin
            mon_d = done_q.pop_front();
            check("death_done", 32'(death_done), 32'(mon_d.done));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int x, input int y, input logic tk, input logic d, input logic r);
        logic ball, done;
        logic [23:0] rgb;
        int addr;
        pix_t e;
        done_t dn;
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y);
        frame_tick = tk; die = d; respawn = r;
        PacX = n_px; PacY = n_py; Dir = n_dir; moving = n_mv;
        #1;
        model_pixel(x, y, ball, rgb, addr);
        if (m_state != 2) check("rom_addr", 32'(rom_addr), 32'(addr));
        e = '{cyc + 2, ball, rgb, 10'(x), 10'(y)};
        pix_q.push_back(e);
        done = 1'b0;
        if (tk) begin
            m_px = int'(n_px); m_py = int'(n_py); m_dir = int'(n_dir);
        end
        if (m_state == 0) begin
            if (d) begin m_state = 1; m_die_ticks = 0; end
            else if (tk && n_mv) m_anim_ticks++;
        end else if (m_state == 1) begin
            if (tk) begin
                m_die_ticks++;
                if (m_die_ticks == 32) begin m_state = 2; done = 1'b1; end
            end
        end else begin
            if (r && !d) begin m_state = 0; m_anim_ticks = 0; end
        end
        dn = '{cyc + 1, done};
        done_q.push_back(dn);
    endtask

    task automatic in_box_px(input logic tk, input logic d, input logic r);
        step((m_px + int'($urandom_range(0, 15))) & 1023,
             (m_py + int'($urandom_range(0, 15))) & 1023, tk, d, r);
    endtask

    task automatic rand_steps(input int n);
        int x, y;
        logic tk, d, r;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                x = (m_px + int'($urandom_range(0, 23)) - 4) & 1023;
                y = (m_py + int'($urandom_range(0, 23)) - 4) & 1023;
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end
            tk = ($urandom_range(0, 5) == 0);
            d  = (m_state == 0) ? ($urandom_range(0, 150) == 0) : ($urandom_range(0, 40) == 0);
            r  = (m_state == 2) ? ($urandom_range(0, 10) == 0)  : ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 30) == 0) begin
                n_px  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom);
                n_py  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom);
                n_dir = 2'($urandom);
                n_mv  = ($urandom_range(0, 3) != 0);
            end
            step(x, y, tk, d, r);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_is_ball"}, 32'(is_ball), 32'd0);
        check({tag, "_rgb"}, {8'd0, out_r, out_g, out_b}, 32'd0);
        check({tag, "_xd"}, 32'(DrawX_d), 32'd0);
        check({tag, "_yd"}, 32'(DrawY_d), 32'd0);
        check({tag, "_done"}, 32'(death_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pal = '{24'h000000, 24'hFFFF00, 24'h000000, 24'hFFFFFF,
                24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFB8FF,
                24'h00FFFF, 24'hFFB852, 24'h2121DE, 24'hDEDEFF,
                24'hFF8000, 24'h808080, 24'h400040, 24'hC0C0C0};
        seq = '{0, 1, 2, 1};
        for (int i = 0; i < 4096; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
        rom_mem[0 * 256 + 5 * 16 + 3] = 4'd1;

        Reset = 1'b1;
        frame_tick = 1'b0; moving = 1'b0; die = 1'b0; respawn = 1'b0;
        DrawX = 10'd123; DrawY = 10'd45; PacX = 10'd120; PacY = 10'd40; Dir = 2'd0;
        n_px = 10'd0; n_py = 10'd0; n_dir = 2'd0; n_mv = 1'b0;
        model_reset();

        // Async reset between clock edges: outputs clear without a Clk edge.
        #12 Reset = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge Clk);
        check_outputs_zero("reset_hold");
        #2 Reset = 1'b1;

        // Pac at (100,200) facing RIGHT; ROM index 1 at (3,5).
        n_px = 10'd100; n_py = 10'd200; n_dir = 2'd0; n_mv = 1'b0;
        step(0, 0, 1'b1, 1'b0, 1'b0);
        step(103, 205, 1'b0, 1'b0, 1'b0);
        step(116, 205, 1'b0, 1'b0, 1'b0);
        step(115, 215, 1'b0, 1'b0, 1'b0);
        step(99, 205, 1'b0, 1'b0, 1'b0);
        step(100, 216, 1'b0, 1'b0, 1'b0);

        // Facing UP latched; later Dir change without a tick has no effect.
        n_dir = 2'd2;
        step(0, 0, 1'b1, 1'b0, 1'b0);
        step(100, 200, 1'b0, 1'b0, 1'b0);
        check("up_addr", 32'(rom_addr), 32'h00F);
        n_dir = 2'd3;
        step(100, 200, 1'b0, 1'b0, 1'b0);
        check("up_addr_hold", 32'(rom_addr), 32'h00F);
        for (int i = 0; i < 4; i++) begin
            n_dir = 2'(i);
            step(0, 0, 1'b1, 1'b0, 1'b0);
            repeat (4) in_box_px(1'b0, 1'b0, 1'b0);
        end

        // Chomp cycle: 16 moving ticks, then frozen while not moving.
        n_mv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_box_px(1'b1, 1'b0, 1'b0);
            repeat (2) in_box_px(1'b0, 1'b0, 1'b0);
        end
        n_mv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_box_px(1'b1, 1'b0, 1'b0);
            in_box_px(1'b0, 1'b0, 1'b0);
        end
        n_mv = 1'b1;
        repeat (5) begin
            in_box_px(1'b1, 1'b0, 1'b0);
            in_box_px(1'b0, 1'b0, 1'b0);
        end

        // Death: die together with a tick, 32 ticks to DEAD, ignored events.
        in_box_px(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 36; i++) begin
            in_box_px(1'b1, (i == 3), (i == 5));
            repeat (2) in_box_px(1'b0, 1'b0, 1'b0);
        end
        repeat (3) in_box_px(1'b0, 1'b1, 1'b0);
        in_box_px(1'b0, 1'b1, 1'b1);
        in_box_px(1'b0, 1'b0, 1'b1);
        repeat (4) in_box_px(1'b0, 1'b0, 1'b1);

        // Right-edge clipping: no wrap to DrawX=0..3.
        n_px = 10'd1020; n_py = 10'd300; n_dir = 2'd0;
        step(0, 0, 1'b1, 1'b0, 1'b0);
        for (int x = 1018; x < 1024; x++) step(x, 305, 1'b0, 1'b0, 1'b0);
        for (int x = 0; x < 4; x++) step(x, 305, 1'b0, 1'b0, 1'b0);

        rand_steps(3000);

        // Mid-frame reset with pixels in flight.
        repeat (3) in_box_px(1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1 check_outputs_zero("midreset");
        pix_q.delete();
        done_q.delete();
        model_reset();
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b1;
        repeat (4) step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);

        rand_steps(800);

        step(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge Clk);
        check("drain_pix", 32'(pix_q.size()), 32'd0);
        check("drain_done", 32'(done_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pacman_sprite_renderer.md
Name: pacman_sprite_renderer

Overview:
- Upstream pixel source for color_mapper. Produces is_ball and pac_man_cut_data_out_R/G/B for each pixel.
- Fetches 4-bit palette indices from an external synchronous sprite ROM, rotates or mirrors the 16x16 sprite by direction, and converts indices to RGB through a constant palette.
- Runs the chomp and death animation state machine, ticked once per video frame.
- Clk is the pixel clock. DrawX/DrawY advance by one pixel per Clk.

Parameters:
- SPR_SIZE, 16: sprite edge in pixels. Fixed at 16; local coordinates are 4 bits.
- ANIM_DIV, 4: frame_tick pulses per animation step.
- DEATH_FRAMES, 8: number of death frames, stored at ROM frames 4..11.

Ports:
- Clk, in, 1: pixel clock; the only clock.
- Reset, in, 1: asynchronous, active-low reset.
- frame_tick, in, 1: one-Clk pulse at start of vertical blank.
- DrawX, in, 10: current pixel X.
- DrawY, in, 10: current pixel Y.
- PacX, in, 10: sprite top-left X.
- PacY, in, 10: sprite top-left Y.
- Dir, in, 2: facing; 0=RIGHT, 1=LEFT, 2=UP, 3=DOWN.
- moving, in, 1: chomp animation advances only while high.
- die, in, 1: one-Clk pulse; starts death sequence.
- respawn, in, 1: one-Clk pulse; leaves DEAD.
- rom_addr, out, 12: {frame[3:0], sy[3:0], sx[3:0]}. Combinational from DrawX/DrawY and latched state.
- rom_data, in, 4: palette index; valid one Clk after rom_addr.
- is_ball, out, 1: pixel is opaque sprite.
- pac_man_cut_data_out_R, out, 8: sprite red.
- pac_man_cut_data_out_G, out, 8: sprite green.
- pac_man_cut_data_out_B, out, 8: sprite blue.
- DrawX_d, out, 10: DrawX delayed 2 Clk, aligned with the colour outputs.
- DrawY_d, out, 10: DrawY delayed 2 Clk, aligned with the colour outputs.
- death_done, out, 1: one-Clk pulse on DYING->DEAD.

Behaviour:
- Reset (Reset=0, async):
  - All outputs 0.
  - State ALIVE, chomp phase 0, divider 0.
  - pos_q=0, dir_q=RIGHT.
- Latching: PacX, PacY and Dir are captured into pos_q/dir_q only on frame_tick, so there is no mid-frame tearing.
- Hit test:
  - lx = DrawX - pos_q.X and ly = DrawY - pos_q.Y, computed in 11 bits.
  - in_box = DrawX >= pos_q.X && DrawX < pos_q.X+16, with the same test on Y, all in 11-bit arithmetic. A sprite at X=1016..1023 clips and does not wrap to 0.
- Orientation, applied only in ALIVE (DYING always uses RIGHT):
  - RIGHT: (sx,sy) = (lx,ly)
  - LEFT: (15-lx, ly)
  - UP: (15-ly, lx)
  - DOWN: (ly, lx)
- Frame select:
  - ALIVE: chomp frame from the sequence 0,1,2,1 (wide, half, closed, half).
  - DYING: 4+death_idx.
  - DEAD: in_box forced 0.
- Pipeline, latency 2 Clk:
  - Stage 1 registers in_box, DrawX and DrawY while the ROM reads.
  - Stage 2 registers is_ball = in_box_s1 && rom_data!=0, RGB = PALETTE[rom_data] (0 when not is_ball), and DrawX_d/DrawY_d.
- State machine:
  - ALIVE: on frame_tick with moving=1, increment divider. When the divider reaches ANIM_DIV-1, clear it and advance phase mod 4. With moving=0, phase and divider hold.
  - ALIVE -> DYING on die: death_idx=0, divider=0.
  - DYING: death_idx increments every ANIM_DIV frame_ticks. At death_idx=DEATH_FRAMES-1 plus a full divider period, go to DEAD and pulse death_done.
  - DEAD -> ALIVE on respawn: phase 0, divider 0.
- Simultaneous events:
  - die and respawn together: die wins.
  - die in DYING or DEAD: ignored.
  - respawn in ALIVE or DYING: ignored.
  - die together with frame_tick: enter DYING with divider 0; the tick is not counted.
- Frame and state changes take effect on the Clk after the event. Pixels already in the pipeline complete with their old values.

Decomposition:
- Package pacman_pkg holds:
  - dir_t enum (RIGHT, LEFT, UP, DOWN)
  - anim_state_t enum (ALIVE, DYING, DEAD)
  - PALETTE: 16x24-bit constant; entry 0 transparent, 1 = FFFF00 yellow, 2 = 000000 eye
  - CHOMP_SEQ constant
  - SPR_SIZE
- One sub-module, pacman_anim_fsm: state, divider, phase, death_idx, death_done; outputs frame[3:0] and visible.

Test Plan:
- Reset low mid-frame -> all outputs 0 immediately and no Clk needed; after release, ALIVE phase 0.
- Pac at (100,200), Dir=RIGHT, ROM index 1 at (lx,ly)=(3,5) -> two Clk after DrawX=103, DrawY=205: is_ball=1, RGB=FF/FF/00, DrawX_d=103. At DrawX=116: is_ball=0.
- Dir=UP latched, screen pixel (lx,ly)=(0,0) -> rom_addr sx=15, sy=0. Dir change without frame_tick leaves rom_addr unchanged.
- moving=1, ANIM_DIV=4, 16 frame_ticks -> frame sequence 0,1,2,1 with 4 ticks each. Dropping moving freezes the frame.
- die then 32 frame_ticks -> frames 4..11, 4 ticks each. death_done is a single pulse at the DYING->DEAD transition. is_ball stays 0 in DEAD until respawn; respawn gives frame 0.
- PacX=1020 -> DrawX=1023 gives is_ball per ROM. DrawX=0..3 gives is_ball=0 (no wrap).
